// File: rtl/mac_scheduler_if.sv
// Bus between the MAC scheduler, its requesters, the shared multiplier and the result consumer.
// master = scheduler side, slave = requesters / multiplier / consumer side.
interface mac_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int TAP_W = 6,
    parameter int ID_W  = 2
);
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  grant;
    logic [TAP_W-1:0] tap_idx;
    logic [31:0]      product;
    logic [31:0]      result;
    logic [ID_W-1:0]  result_id;
    logic             result_valid;
    logic             result_ready;
    logic             busy;

    modport master (
        input  req, product, result_ready,
        output grant, tap_idx, result, result_id, result_valid, busy
    );

    modport slave (
        output req, product, result_ready,
        input  grant, tap_idx, result, result_id, result_valid, busy
    );
endinterface

// File: rtl/mac_scheduler.sv
// Round-robin job scheduler for one shared multiply-accumulate datapath: sequences taps,
// accumulates products and hands the dot product back with the owner's ID.
//
// state | meaning
// IDLE  | no job; arbitrate among req starting at prio_ptr
// RUN   | stepping tap_idx 0..NTAPS-1 and accumulating product
// DONE  | result_valid high, waiting for result_ready
module mac_scheduler #(
    parameter int NREQ  = 4,
    parameter int NTAPS = 64,
    parameter int TAP_W = 6,
    parameter int ID_W  = 2
) (
    input logic            clk,
    input logic            reset_n,
    mac_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NREQ - 1);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]  prio_ptr_q, prio_ptr_d;
    logic [TAP_W-1:0] tap_idx_q, tap_idx_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      result_q, result_d;
    logic [ID_W-1:0]  result_id_q, result_id_d;
    logic             result_valid_q, result_valid_d;
    logic             busy_q, busy_d;

    logic [ID_W-1:0]  pick_id;

    // First requester at or above prio_ptr, wrapping modulo NREQ.
    always_comb begin : arb
        logic found;
        int   cand;
        found   = 1'b0;
        pick_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(prio_ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && bus.req[cand]) begin
                found   = 1'b1;
                pick_id = ID_W'(cand);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        gnt_id_d       = gnt_id_q;
        prio_ptr_d     = prio_ptr_q;
        tap_idx_d      = tap_idx_q;
        acc_d          = acc_q;
        result_d       = result_q;
        result_id_d    = result_id_q;
        result_valid_d = result_valid_q;
        busy_d         = busy_q;

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d          = RUN;
                    grant_d          = '0;
                    grant_d[pick_id] = 1'b1;
                    gnt_id_d         = pick_id;
                    tap_idx_d        = '0;
                    acc_d            = '0;
                    busy_d           = 1'b1;
                end
            end
            RUN: begin
                acc_d = acc_q + bus.product;
                if (tap_idx_q == LAST_TAP) begin
                    result_d       = acc_q + bus.product;
                    result_id_d    = gnt_id_q;
                    result_valid_d = 1'b1;
                    state_d        = DONE;
                end else begin
                    tap_idx_d = tap_idx_q + TAP_W'(1);
                end
            end
            DONE: begin
                if (bus.result_ready) begin
                    result_valid_d = 1'b0;
                    grant_d        = '0;
                    tap_idx_d      = '0;
                    busy_d         = 1'b0;
                    prio_ptr_d     = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + ID_W'(1);
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            gnt_id_q       <= '0;
            prio_ptr_q     <= '0;
            tap_idx_q      <= '0;
            acc_q          <= '0;
            result_q       <= '0;
            result_id_q    <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            gnt_id_q       <= gnt_id_d;
            prio_ptr_q     <= prio_ptr_d;
            tap_idx_q      <= tap_idx_d;
            acc_q          <= acc_d;
            result_q       <= result_d;
            result_id_q    <= result_id_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.tap_idx      = tap_idx_q;
    assign bus.result       = result_q;
    assign bus.result_id    = result_id_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_mac_scheduler.sv
// Directed bench for mac_scheduler: job table plus hand-written fairness, backpressure,
// reset-mid-job and request-drop sequences.
module tb_mac_scheduler;
    logic        clk;
    logic        reset_n;
    bit          prod_tap;
    logic [31:0] prod_const;
    int          n_cmp;
    int          n_bad;

    mac_scheduler_if #(.NREQ(4), .TAP_W(6), .ID_W(2)) bus ();

    mac_scheduler #(.NREQ(4), .NTAPS(64), .TAP_W(6), .ID_W(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Multiplier stand-in: combinational from tap_idx.
    assign bus.product = prod_tap ? (32'(bus.tap_idx) + 32'd1) : prod_const;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  req;
        bit          tap_mode;
        logic [31:0] pconst;
        logic [31:0] exp_res;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Counts edges until result_valid is seen at a falling edge; -1 on timeout.
    task automatic wait_valid(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                n = k;
                break;
            end
        end
        if (n < 0) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_tap(input logic [5:0] t, input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.tap_idx === t) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("tap_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},   32'(bus.grant), 32'd0);
        chk({tag, "_tap"},     32'(bus.tap_idx), 32'd0);
        chk({tag, "_result"},  bus.result, 32'd0);
        chk({tag, "_id"},      32'(bus.result_id), 32'd0);
        chk({tag, "_valid"},   32'(bus.result_valid), 32'd0);
        chk({tag, "_busy"},    32'(bus.busy), 32'd0);
    endtask

    initial begin
        int          n;
        logic [31:0] r0;
        n_cmp          = 0;
        n_bad          = 0;
        reset_n        = 1'b0;
        bus.req        = 4'b0000;
        bus.result_ready = 1'b0;
        prod_tap       = 1'b0;
        prod_const     = 32'd0;

        vecs[0] = '{4'b0001, 1'b0, 32'd1,          32'd64,         2'd0};
        vecs[1] = '{4'b0100, 1'b1, 32'd0,          32'd2080,       2'd2};
        vecs[2] = '{4'b0011, 1'b0, 32'h8000_0001,  32'h0000_0040,  2'd0};
        vecs[3] = '{4'b0011, 1'b0, 32'd2,          32'd128,        2'd1};
        vecs[4] = '{4'b1000, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFC0,  2'd3};
        vecs[5] = '{4'b1010, 1'b0, 32'd3,          32'd192,        2'd1};

        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Fairness: all requesting, ids must rotate 0,1,2,3,0 with 66-cycle spacing.
        bus.req          = 4'b1111;
        prod_tap         = 1'b1;
        bus.result_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            wait_valid(200, n);
            chk($sformatf("fair%0d_spacing", j), n, (j == 0) ? 32'd65 : 32'd66);
            chk($sformatf("fair%0d_id", j), 32'(bus.result_id), 32'(j % 4));
            chk($sformatf("fair%0d_result", j), bus.result, 32'd2080);
            chk($sformatf("fair%0d_grant", j), 32'(bus.grant), 32'd1 << (j % 4));
        end
        bus.req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        chk("fair_idle_busy", 32'(bus.busy), 32'd0);

        // Job table: one job per record, ready held high.
        for (int v = 0; v < 6; v++) begin
            bus.req    = vecs[v].req;
            prod_tap   = vecs[v].tap_mode;
            prod_const = vecs[v].pconst;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_grant", v), 32'(bus.grant), 32'd1 << vecs[v].exp_id);
            chk($sformatf("vec%0d_busy", v), 32'(bus.busy), 32'd1);
            bus.req = 4'b0000;
            wait_valid(200, n);
            chk($sformatf("vec%0d_latency", v), n + 1, 32'd65);
            chk($sformatf("vec%0d_result", v), bus.result, vecs[v].exp_res);
            chk($sformatf("vec%0d_id", v), 32'(bus.result_id), 32'(vecs[v].exp_id));
            chk($sformatf("vec%0d_grant_done", v), 32'(bus.grant), 32'd1 << vecs[v].exp_id);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_valid_clr", v), 32'(bus.result_valid), 32'd0);
            chk($sformatf("vec%0d_grant_clr", v), 32'(bus.grant), 32'd0);
        end

        // Backpressure: hold ready low in DONE while others request.
        bus.result_ready = 1'b0;
        bus.req          = 4'b0010;
        prod_tap         = 1'b0;
        prod_const       = 32'd5;
        wait_valid(200, n);
        chk("bp_latency", n, 32'd65);
        bus.req = 4'b1111;
        r0 = bus.result;
        chk("bp_result", r0, 32'd320);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp%0d_result", k), bus.result, 32'd320);
            chk($sformatf("bp%0d_id", k), 32'(bus.result_id), 32'd1);
            chk($sformatf("bp%0d_grant", k), 32'(bus.grant), 32'b0010);
            chk($sformatf("bp%0d_busy", k), 32'(bus.busy), 32'd1);
            chk($sformatf("bp%0d_valid", k), 32'(bus.result_valid), 32'd1);
        end
        bus.result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_xfer_valid", 32'(bus.result_valid), 32'd0);
        chk("bp_xfer_grant", 32'(bus.grant), 32'd0);
        chk("bp_xfer_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_grant", 32'(bus.grant), 32'b0100);

        // Reset in the middle of that job, then a clean job for requester 2.
        bus.req = 4'b0000;
        wait_tap(6'd30, 100);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        chk_all_zero("midrst_hold");
        reset_n    = 1'b1;
        bus.req    = 4'b0100;
        prod_const = 32'd7;
        wait_valid(200, n);
        chk("rst_job_latency", n, 32'd65);
        chk("rst_job_result", bus.result, 32'd448);
        chk("rst_job_id", 32'(bus.result_id), 32'd2);
        bus.req = 4'b0000;
        @(posedge clk);
        @(negedge clk);

        // Requester 1 drops req at tap 10; job still completes.
        bus.req    = 4'b0010;
        prod_const = 32'd1;
        wait_tap(6'd10, 100);
        chk("drop_grant", 32'(bus.grant), 32'b0010);
        bus.req = 4'b0000;
        wait_valid(200, n);
        chk("drop_result", bus.result, 32'd64);
        chk("drop_id", 32'(bus.result_id), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("drop_idle_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mac_scheduler.md
# mac_scheduler

Controller that shares one 64-tap multiply-accumulate datapath among NREQ requesters. Round-robin arbitration picks a requester, then the block sequences the tap index 0..NTAPS-1 into the external d/cmem element mux and multiplier, and accumulates the returned products. The finished 32-bit dot product is returned with the requester ID over a valid/ready handshake. It sits between the filter-job requesters and the shared multiplier, and replaces free-running tap sequencing with on-demand jobs.

## Interface
- NREQ, 4, number of requesters (2..8)
- NTAPS, 64, taps per job (2..64)
- TAP_W, 6, tap index width (clog2 of NTAPS, min 1)
- ID_W, 2, result ID width (clog2 of NREQ, min 1)

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester job request, level-sensitive
- grant  out  NREQ  one-hot; the owner of the current job
- tap_idx  out  TAP_W  element index driven to the d/cmem mux
- product  in  32  multiplier output for the current tap_idx (combinational path)
- result  out  32  accumulated dot product
- result_id  out  ID_W  index of the requester that owns result
- result_valid  out  1  result and result_id are valid
- result_ready  in  1  consumer accepts the result
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - If any req bit is high, pick the first set bit at or after prio_ptr, searching upward and wrapping modulo NREQ.
  - Next edge: grant gets that bit, state goes to RUN, tap_idx = 0, acc = 0.
- RUN:
  - Each edge: acc <= acc + product; tap_idx increments.
  - On the edge where tap_idx = NTAPS-1: result <= acc + product, result_id <= index of the granted requester, result_valid <= 1, state goes to DONE.
  - tap_idx holds NTAPS-1 and does not wrap past it.
- DONE:
  - result, result_id and grant hold stable while result_ready is low.
  - On an edge with result_ready high: result_valid <= 0, grant <= 0, tap_idx <= 0, prio_ptr <= (granted index + 1) mod NREQ, state goes to IDLE.
- Arithmetic: the accumulator and result are 32-bit unsigned and wrap modulo 2^32. No saturation, no overflow flag.
- req changes after grant are ignored. Dropping req mid-job does not abort the job; the result is still delivered.
- A requester whose req is still high after its result transfers is eligible again. The rotated pointer gives the other requesters precedence first.
- Reset at any point:
  - Aborts the job and discards the partial sum.
  - Returns to IDLE with prio_ptr = 0.

## Timing
- Reset values:
  - grant = 0, tap_idx = 0, result = 0, result_id = 0
  - result_valid = 0, busy = 0
  - internal acc = 0, prio_ptr = 0
- All outputs are registered. product is sampled combinationally from the tap_idx of the same cycle; the multiplier must settle within one cycle.
- Latency:
  - req sampled high in IDLE at edge E0.
  - grant and busy rise after E0.
  - result_valid rises after edge E0+NTAPS (65 edges for the defaults).
- Handshake: transfer occurs on an edge where result_valid && result_ready. result_ready may be held high ahead of time; the transfer then happens on the first edge in DONE.
- Throughput: one IDLE cycle between jobs, so back-to-back jobs start every NTAPS+2 cycles with result_ready held high.
- Simultaneous requests: only one grant per job, and grant is always one-hot or zero.
- reset_n deassertion is synchronized by the system. The first arbitration occurs on the first edge after release.

## Test plan
- Single job: req=4'b0001, product=1 on every tap, result_ready=1. Required: result=64, result_id=0, result_valid high exactly after edge 65, grant=4'b0001 throughout, then IDLE.
- Fairness: req=4'b1111 held, product=tap_idx+1. Required: result_ids in order 0,1,2,3,0, each result=2080, and a 66-cycle job spacing.
- Backpressure: result_ready low for 10 cycles in DONE. Required: result, result_id, grant and busy stable; no new grant; transfer on the first ready edge.
- Wrap: product=32'h8000_0001 for 64 taps. Required: result=32'h0000_0040.
- Reset mid-job: assert reset_n=0 at tap_idx=30. Required: all outputs zero immediately. After release with req=4'b0100, the next job yields a fresh, complete result with result_id=2.
- Request drop: req[1] deasserted at tap 10 of its job. Required: the job completes and result is delivered with result_id=1.
